v6_peak_detector: RTL and testbench



---
 rtl/v6_peak_detector_if.sv | 27 ++
 rtl/v6_peak_detector.sv | 137 +++++++++++++
 tb/tb_v6_peak_detector.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/v6_peak_detector_if.sv
// Sample-stream and event bus between the trapezoidal filter, the peak detector
// and the histogram/readout logic.
interface v6_peak_detector_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned TS_W   = 32,
  parameter int unsigned WID_W  = 16
);
  logic signed [DATA_W-1:0] in_data;
  logic                     in_valid;
  logic signed [DATA_W-1:0] threshold;
  logic signed [DATA_W-1:0] peak_data;
  logic [TS_W-1:0]          peak_time;
  logic [WID_W-1:0]         peak_width;
  logic                     peak_pileup;
  logic                     peak_valid;
  logic                     busy;

  modport master (
    output in_data, in_valid, threshold,
    input  peak_data, peak_time, peak_width, peak_pileup, peak_valid, busy
  );

  modport slave (
    input  in_data, in_valid, threshold,
    output peak_data, peak_time, peak_width, peak_pileup, peak_valid, busy
  );
endinterface

// File: rtl/v6_peak_detector.sv
// Threshold-crossing pulse detector: reports flat-top maximum, its timestamp,
// pulse width and pile-up flag once per qualified pulse.
module v6_peak_detector #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned TS_W      = 32,
  parameter int unsigned WID_W     = 16,
  parameter int unsigned MIN_WIDTH = 4,
  parameter int unsigned MAX_WIDTH = 64,
  parameter int unsigned HOLDOFF   = 8
) (
  input  logic               clk,
  input  logic               reset,
  v6_peak_detector_if.slave  bus
);

  localparam int unsigned HCNT_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [TS_W-1:0]          ts_q, ts_d;
  logic signed [DATA_W-1:0] max_q, max_d;
  logic [TS_W-1:0]          max_ts_q, max_ts_d;
  logic [WID_W-1:0]         width_q, width_d;
  logic [HCNT_W-1:0]        hcnt_q, hcnt_d;
  logic signed [DATA_W-1:0] peak_data_q, peak_data_d;
  logic [TS_W-1:0]          peak_time_q, peak_time_d;
  logic [WID_W-1:0]         peak_width_q, peak_width_d;
  logic                     peak_pileup_q, peak_pileup_d;
  logic                     peak_valid_q, peak_valid_d;
  logic                     busy_q, busy_d;
  logic                     above_c;

  assign above_c = bus.in_data > bus.threshold;

  // Next-state and event capture; every register holds while in_valid is low.
  always_comb begin
    state_d       = state_q;
    ts_d          = ts_q;
    max_d         = max_q;
    max_ts_d      = max_ts_q;
    width_d       = width_q;
    hcnt_d        = hcnt_q;
    peak_data_d   = peak_data_q;
    peak_time_d   = peak_time_q;
    peak_width_d  = peak_width_q;
    peak_pileup_d = peak_pileup_q;
    peak_valid_d  = 1'b0;

    if (bus.in_valid) begin
      ts_d = ts_q + TS_W'(1);
      unique case (state_q)
        IDLE: begin
          if (above_c) begin
            state_d  = ARMED;
            max_d    = bus.in_data;
            max_ts_d = ts_q;
            width_d  = WID_W'(1);
          end
        end
        ARMED: begin
          if (above_c) begin
            if (width_q != '1) width_d = width_q + WID_W'(1);
            // Strict compare keeps the earliest sample of a flat top.
            if (bus.in_data > max_q) begin
              max_d    = bus.in_data;
              max_ts_d = ts_q;
            end
          end else begin
            if (32'(width_q) >= MIN_WIDTH) begin
              peak_data_d   = max_q;
              peak_time_d   = max_ts_q;
              peak_width_d  = width_q;
              peak_pileup_d = 32'(width_q) > MAX_WIDTH;
              peak_valid_d  = 1'b1;
            end
            if (HOLDOFF == 0) begin
              state_d = IDLE;
            end else begin
              state_d = HOLD;
              hcnt_d  = HCNT_W'(HOLDOFF);
            end
          end
        end
        HOLD: begin
          hcnt_d = hcnt_q - HCNT_W'(1);
          if (hcnt_q == HCNT_W'(1)) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      ts_q          <= '0;
      max_q         <= '0;
      max_ts_q      <= '0;
      width_q       <= '0;
      hcnt_q        <= '0;
      peak_data_q   <= '0;
      peak_time_q   <= '0;
      peak_width_q  <= '0;
      peak_pileup_q <= 1'b0;
      peak_valid_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      ts_q          <= ts_d;
      max_q         <= max_d;
      max_ts_q      <= max_ts_d;
      width_q       <= width_d;
      hcnt_q        <= hcnt_d;
      peak_data_q   <= peak_data_d;
      peak_time_q   <= peak_time_d;
      peak_width_q  <= peak_width_d;
      peak_pileup_q <= peak_pileup_d;
      peak_valid_q  <= peak_valid_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.peak_data   = peak_data_q;
  assign bus.peak_time   = peak_time_q;
  assign bus.peak_width  = peak_width_q;
  assign bus.peak_pileup = peak_pileup_q;
  assign bus.peak_valid  = peak_valid_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_v6_peak_detector.sv
// Scoreboard bench for v6_peak_detector: directed pulses push expected events,
// a monitor pops and compares on every peak_valid strobe.
`timescale 1ns/1ps
module tb_v6_peak_detector;

  logic clk;
  logic reset;

  v6_peak_detector_if #(.DATA_W(16), .TS_W(32), .WID_W(16)) bus ();

  v6_peak_detector #(
    .DATA_W(16), .TS_W(32), .WID_W(16),
    .MIN_WIDTH(4), .MAX_WIDTH(64), .HOLDOFF(8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic signed [15:0] d;
    logic [31:0]        t;
    logic [15:0]        w;
    logic               p;
  } ev_t;

  ev_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;

  logic signed [15:0] trap [11] = '{16'sd0, 16'sd50, 16'sd150, 16'sd300, 16'sd500, 16'sd500,
                                    16'sd500, 16'sd300, 16'sd150, 16'sd50, 16'sd0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int d, input int t, input int w, input bit p);
    ev_t e;
    e.d = 16'(d);
    e.t = 32'(t);
    e.w = 16'(w);
    e.p = p;
    exp_q.push_back(e);
  endtask

  task automatic send(input int d);
    @(negedge clk);
    bus.in_data  = 16'(d);
    bus.in_valid = 1'b1;
  endtask

  // Idle cycle with above-threshold garbage on the data lines.
  task automatic gap();
    @(negedge clk);
    bus.in_data  = 16'sd1000;
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    reset        = 1'b0;
  endtask

  // Monitor: every strobe must match the oldest expected event.
  always @(negedge clk) begin : monitor
    ev_t e;
    if (bus.peak_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event: got peak_valid=1 (data %0d width %0d) expected no event",
                 bus.peak_data, bus.peak_width);
      end else begin
        e = exp_q.pop_front();
        chk("peak_data",   bus.peak_data,   e.d);
        chk("peak_time",   bus.peak_time,   e.t);
        chk("peak_width",  bus.peak_width,  e.w);
        chk("peak_pileup", bus.peak_pileup, e.p);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.threshold = 16'sd100;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    chk("rst_peak_data",   bus.peak_data,   0);
    chk("rst_peak_time",   bus.peak_time,   0);
    chk("rst_peak_width",  bus.peak_width,  0);
    chk("rst_peak_pileup", bus.peak_pileup, 0);
    chk("rst_peak_valid",  bus.peak_valid,  0);
    chk("rst_busy",        bus.busy,        0);

    // Basic trapezoid
    do_reset();
    push(500, 4, 7, 1'b0);
    for (int i = 0; i < 11; i++) begin
      send(trap[i]);
      if (i == 1) begin
        gap();
        chk("s1_busy_idle", bus.busy, 0);
      end
      if (i == 3) begin
        gap();
        chk("s1_busy_armed", bus.busy, 1);
      end
      if (i == 9) begin
        gap();
        chk("s1_strobe", bus.peak_valid, 1);
      end
    end
    repeat (7) send(0);
    gap();
    chk("s1_busy_end", bus.busy, 0);
    chk("s1_hold_data", bus.peak_data, 500);

    // Short spike below MIN_WIDTH, holdoff length
    do_reset();
    send(0); send(200); send(300); send(0);
    repeat (7) send(0);
    gap();
    chk("s2_busy_7", bus.busy, 1);
    send(0);
    gap();
    chk("s2_busy_8", bus.busy, 0);

    // Long pulse -> pile-up
    do_reset();
    push(200, 1, 70, 1'b1);
    send(0);
    repeat (70) send(200);
    send(0);
    repeat (8) send(0);
    gap();

    // Holdoff suppression then a MIN_WIDTH pulse right after holdoff
    do_reset();
    push(500, 4, 7, 1'b0);
    push(300, 18, 4, 1'b0);
    for (int i = 0; i < 10; i++) send(trap[i]);
    send(0); send(0);
    repeat (5) send(400);
    send(0);
    repeat (4) send(300);
    send(0);
    repeat (8) send(0);
    gap();

    // Trapezoid with gaps between samples
    do_reset();
    push(500, 4, 7, 1'b0);
    for (int i = 0; i < 11; i++) begin
      send(trap[i]);
      gap();
      if (i == 8) chk("s5_strobe_early", bus.peak_valid, 0);
      if (i == 9) chk("s5_strobe", bus.peak_valid, 1);
    end
    repeat (8) begin
      send(0);
      gap();
    end

    // Reset mid-pulse clears held outputs and restarts ts
    repeat (4) send(0);
    send(150); send(300); send(500);
    do_reset();
    chk("s6_peak_data",   bus.peak_data,   0);
    chk("s6_peak_time",   bus.peak_time,   0);
    chk("s6_peak_width",  bus.peak_width,  0);
    chk("s6_peak_pileup", bus.peak_pileup, 0);
    chk("s6_busy",        bus.busy,        0);
    push(250, 2, 4, 1'b0);
    send(0); send(200); send(250); send(250); send(200); send(0);
    repeat (8) send(0);
    gap();

    // Negative threshold and samples
    do_reset();
    bus.threshold = -16'sd50;
    push(-10, 1, 4, 1'b0);
    send(-20); send(-10); send(-10); send(-30); send(-60);
    repeat (8) send(-100);
    gap();

    repeat (3) gap();
    chk("events_pending", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
